sa_os_seq_ctrl: RTL and testbench
=================================

Name: sa_os_seq_ctrl

Overview:
- Run sequencer for the output-stationary 2D systolic MAC array of radix-8 Booth PEs.
- One start launches one tile:
  - clears the PE accumulators;
  - streams k_len operand words from the A/B operand buffers into the array edges;
  - generates the diagonal lane-valid skew;
  - waits for the array to flush, then pulses a capture strobe for the MAC outputs.
- Sits between the tile scheduler (start/done) and the array plus its operand buffers.

Parameters:
- HPE, 64: array edge size; number of A lanes = number of B lanes = HPE.
- K_W, 16: width of the accumulation-length counter and buffer read address.
- PIPE_LAT, 2: cycles from a PE's operand arrival to its accumulator update (Booth pre-process register + PE MAC register).

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous active-low reset.
- start  in  1  launch request; sampled only in IDLE.
- k_len  in  K_W  accumulation length; sampled with start.
- abort  in  1  cancel current run.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- acc_clr  out  1  synchronous clear to all PE accumulators.
- rd_en  out  1  operand-buffer read enable; read data returns 1 cycle later.
- rd_addr  out  K_W  operand-buffer read index.
- lane_vld  out  HPE  per-lane operand valid, bit z = lane z (skewed).
- cap_en  out  1  one-cycle strobe: the array Y bus holds final results.

Behaviour:
- Reset: one clock (CLK); reset RST is synchronous, active-low.
- While RST=0 at a rising edge:
  - state goes to IDLE;
  - all outputs go to 0 (busy, done, acc_clr, rd_en, cap_en, rd_addr, lane_vld);
  - internal counters go to 0.
- Reset mid-run: immediate return to IDLE, no done.
- FSM states: IDLE, CLEAR, FEED, FLUSH, CAPTURE, DONE.
  - IDLE: start=1 and k_len!=0 -> CLEAR; latch k_len into klen_r.
  - IDLE: start=1 and k_len==0 -> DONE directly. No clear, no reads, no capture.
  - CLEAR (1 cycle): acc_clr=1 -> FEED.
  - FEED (klen_r cycles): rd_en=1; rd_addr counts 0..klen_r-1, incrementing by 1 per cycle -> FLUSH after the last read.
  - FLUSH: F = 2*(HPE-1)+PIPE_LAT+1 cycles. The +1 covers buffer read latency; 2*(HPE-1) covers the row+column skew to the far corner PE. -> CAPTURE.
  - CAPTURE (1 cycle): cap_en=1 -> DONE.
  - DONE (1 cycle): done=1 -> IDLE.
- Output registering: all outputs are registered and decoded from the current state. rd_addr is 0 outside FEED.
- lane_vld is a shift register updated every cycle:
  - lane_vld <= {lane_vld[HPE-2:0], (state==FEED)};
  - lane z is therefore high for exactly klen_r consecutive cycles, starting z+1 cycles after the first FEED cycle;
  - it drains naturally to 0 during FLUSH.
- Latency, start sampled at edge 0 with k_len = K: CLEAR at cycle 1, FEED at cycles 2..K+1, FLUSH at K+2..K+1+F, CAPTURE at K+2+F, DONE at K+3+F.
- busy is high cycles 1..K+3+F.
- start while busy: ignored; no queueing.
- start in the same cycle as the DONE state: ignored. A new run requires IDLE.
- abort: in any non-IDLE state except DONE -> IDLE next cycle.
  - lane_vld cleared to 0 in that same transition.
  - No cap_en, no done.
  - acc_clr is not issued on abort; the next run's CLEAR handles it.
- abort in DONE: ignored; done still pulses.
- abort has priority over every state transition.
- klen_r is held constant for the whole run; k_len changes after start have no effect.
- Max k_len: 2^K_W-1. rd_addr never wraps within a run.
- Counters: one K_W-bit FEED counter and one flush counter of width clog2(F+1). No arithmetic on data.

Test Plan:
- All tests use HPE=4, PIPE_LAT=2, so F=9.
- Reset: hold RST=0 for 3 cycles with start=1 -> all outputs 0, busy=0; after RST=1 with start=0, stays IDLE.
- Nominal: start=1, k_len=3 at edge 0 ->
  - acc_clr at cycle 1;
  - rd_en at cycles 2-4 with rd_addr 0,1,2;
  - lane_vld[0] at cycles 3-5, lane_vld[3] at cycles 6-8;
  - cap_en at cycle 14, done at cycle 15;
  - busy at cycles 1-15, busy=0 at cycle 16.
- Zero length: start=1, k_len=0 -> done at cycle 1, busy only at cycle 1; acc_clr, rd_en and cap_en never assert.
- Start while busy: second start at cycle 5 with k_len=7 during a k_len=3 run -> timing identical to the nominal case, and no second run afterwards.
- Abort: k_len=5, abort=1 at cycle 4 (FEED) -> IDLE at cycle 5, lane_vld=0 at cycle 5, no cap_en, no done. A new start at cycle 6 runs nominally.
- Back-to-back and reset mid-run:
  - start held high continuously -> the next run's CLEAR occurs 2 cycles after done;
  - RST=0 at cycle 10 of a run -> all outputs 0 at cycle 11, no done.

Source files
------------

// File: rtl/sa_os_seq_ctrl.sv
// Tile run sequencer for the output-stationary systolic MAC array: clears the
// accumulators, streams operands with a diagonal lane skew, waits out the flush, captures.
module sa_os_seq_ctrl #(
    parameter int HPE      = 64,
    parameter int K_W      = 16,
    parameter int PIPE_LAT = 2
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           start,
    input  logic [K_W-1:0] k_len,
    input  logic           abort,
    output logic           busy,
    output logic           done,
    output logic           acc_clr,
    output logic           rd_en,
    output logic [K_W-1:0] rd_addr,
    output logic [HPE-1:0] lane_vld,
    output logic           cap_en
);

    // Flush length: skew to the far corner PE, PE pipeline, plus one cycle of buffer read latency.
    localparam int F    = 2 * (HPE - 1) + PIPE_LAT + 1;
    localparam int FL_W = $clog2(F + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_FEED    = 3'd2,
        S_FLUSH   = 3'd3,
        S_CAPTURE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [K_W-1:0]  klen_r;
    logic [K_W-1:0]  rd_addr_nxt;
    logic [FL_W-1:0] fl_cnt;
    logic [FL_W-1:0] fl_nxt;
    logic            abort_hit;

    // Scheduler handshake: start is honoured only while idle (busy=0); each accepted
    // start yields exactly one done pulse unless aborted or reset. No queueing.
    assign abort_hit = abort && (state != S_IDLE) && (state != S_DONE);

    always_comb begin
        state_nxt   = state;
        rd_addr_nxt = '0;
        fl_nxt      = '0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = (k_len != '0) ? S_CLEAR : S_DONE;
            end
            S_CLEAR: state_nxt = S_FEED;
            S_FEED: begin
                // rd_addr doubles as the feed counter; it is 0 outside FEED.
                if (rd_addr == klen_r - K_W'(1)) state_nxt = S_FLUSH;
                else                             rd_addr_nxt = rd_addr + K_W'(1);
            end
            S_FLUSH: begin
                if (fl_cnt == FL_W'(F - 1)) state_nxt = S_CAPTURE;
                else                        fl_nxt    = fl_cnt + FL_W'(1);
            end
            S_CAPTURE: state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        if (abort_hit) begin
            state_nxt   = S_IDLE;
            rd_addr_nxt = '0;
            fl_nxt      = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= S_IDLE;
            klen_r   <= '0;
            rd_addr  <= '0;
            fl_cnt   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            acc_clr  <= 1'b0;
            rd_en    <= 1'b0;
            cap_en   <= 1'b0;
            lane_vld <= '0;
        end else begin
            state   <= state_nxt;
            rd_addr <= rd_addr_nxt;
            fl_cnt  <= fl_nxt;
            if (state == S_IDLE && start) klen_r <= k_len;
            busy    <= (state_nxt != S_IDLE);
            done    <= (state_nxt == S_DONE);
            acc_clr <= (state_nxt == S_CLEAR);
            rd_en   <= (state_nxt == S_FEED);
            cap_en  <= (state_nxt == S_CAPTURE);
            // Lane z sees FEED z+1 cycles late, matching the read latency plus diagonal skew.
            lane_vld <= abort_hit ? '0 : {lane_vld[HPE-2:0], (state == S_FEED)};
        end
    end

endmodule

// File: tb/tb_sa_os_seq_ctrl.sv
// Bench for sa_os_seq_ctrl: directed scenarios then random traffic, every cycle checked
// against a run-timeline model (offsets from the accepted start).
module tb_sa_os_seq_ctrl;
  localparam int HPE      = 4;
  localparam int K_W      = 16;
  localparam int PIPE_LAT = 2;
  localparam int F        = 2 * (HPE - 1) + PIPE_LAT + 1;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic           start = 1'b0;
  logic [K_W-1:0] k_len = '0;
  logic           abort = 1'b0;
  logic           busy, done, acc_clr, rd_en, cap_en;
  logic [K_W-1:0] rd_addr;
  logic [HPE-1:0] lane_vld;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  // model: a run accepted at the end of cycle t0 puts CLEAR at t=1
  bit run_on = 0;
  int t0 = 0;
  int k = 0;

  sa_os_seq_ctrl #(.HPE(HPE), .K_W(K_W), .PIPE_LAT(PIPE_LAT)) dut (
    .CLK(CLK), .RST(RST), .start(start), .k_len(k_len), .abort(abort),
    .busy(busy), .done(done), .acc_clr(acc_clr), .rd_en(rd_en),
    .rd_addr(rd_addr), .lane_vld(lane_vld), .cap_en(cap_en)
  );

  always #5 CLK = ~CLK;

  function automatic int run_end(int kk);
    return (kk == 0) ? 1 : kk + 3 + F;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    int t;
    bit on, e_rd;
    logic [HPE-1:0] e_lane;
    t = cyc - t0;
    on = run_on;
    e_rd = on && k != 0 && t >= 2 && t <= k + 1;
    e_lane = '0;
    for (int z = 0; z < HPE; z++)
      e_lane[z] = on && k != 0 && t >= z + 3 && t <= z + 2 + k;
    check("busy", 32'(busy), 32'(on));
    check("done", 32'(done), 32'(on && t == run_end(k)));
    check("acc_clr", 32'(acc_clr), 32'(on && k != 0 && t == 1));
    check("rd_en", 32'(rd_en), 32'(e_rd));
    check("rd_addr", 32'(rd_addr), e_rd ? 32'(t - 2) : 32'd0);
    check("lane_vld", 32'(lane_vld), 32'(e_lane));
    check("cap_en", 32'(cap_en), 32'(on && k != 0 && t == k + 2 + F));
  endtask

  // one clock: model steps on the same sampled inputs, then outputs are compared
  task automatic tick();
    int t_cur;
    bit idle;
    @(posedge CLK);
    t_cur = cyc - t0;
    idle = !run_on;
    if (!RST)                                           run_on = 0;
    else if (run_on && t_cur < run_end(k) && abort)     run_on = 0;
    else if (idle && start) begin
      run_on = 1;
      t0 = cyc;
      k = int'(k_len);
    end
    else if (run_on && t_cur >= run_end(k))             run_on = 0;
    cyc++;
    #1;
    check_all();
  endtask

  initial begin
    // reset held with start asserted
    RST = 0; start = 1; k_len = 16'd3;
    repeat (3) tick();
    RST = 1; start = 0;
    repeat (3) tick();

    // nominal k=3; k_len scrambled after start must not matter
    start = 1; k_len = 16'd3; tick();
    start = 0; k_len = 16'($urandom_range(1, 9));
    repeat (17) tick();

    // zero length
    start = 1; k_len = 16'd0; tick();
    start = 0;
    repeat (3) tick();

    // start while busy (cycle 5, k=7) is ignored
    start = 1; k_len = 16'd3; tick();
    start = 0;
    repeat (4) tick();
    start = 1; k_len = 16'd7; tick();
    start = 0;
    repeat (25) tick();

    // abort in FEED at cycle 4, restart at cycle 6
    start = 1; k_len = 16'd5; tick();
    start = 0;
    repeat (3) tick();
    abort = 1; tick();
    abort = 0; tick();
    start = 1; k_len = 16'd2; tick();
    start = 0;
    repeat (16) tick();

    // abort during DONE is ignored
    start = 1; k_len = 16'd1; tick();
    start = 0;
    repeat (12) tick();
    abort = 1; tick();
    abort = 0;
    repeat (3) tick();

    // back-to-back with start held high
    start = 1; k_len = 16'd2;
    repeat (40) tick();
    start = 0;
    repeat (20) tick();

    // reset at cycle 10 of a run
    start = 1; k_len = 16'd4; tick();
    start = 0;
    repeat (9) tick();
    RST = 0; tick();
    RST = 1;
    repeat (5) tick();

    // random traffic
    repeat (800) begin
      start = ($urandom_range(0, 3) == 0);
      k_len = 16'($urandom_range(0, 6));
      abort = ($urandom_range(0, 24) == 0);
      RST   = ($urandom_range(0, 59) != 0);
      tick();
    end
    start = 0; abort = 0; RST = 1;
    repeat (25) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
